// File: rtl/pc_irq_unit.sv
// Program counter with one-slot delayed branches and vectored, non-nesting interrupt entry/exit.
// Build option: define PC_ISR_AUTORET_EN to make an ISR return by itself after ISR_LEN instructions.
module pc_irq_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] ISR_BASE     = 32'hBFCF0000,
    parameter logic [31:0] ISR_STRIDE   = 32'h100,
    parameter int          N_IRQ        = 4,
    parameter int          ISR_LEN      = 10,
    localparam int         IDW          = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exec2,
    input  logic             jump_req,
    input  logic [31:0]      jump_target,
    input  logic [N_IRQ-1:0] irq,
    input  logic             isr_return,
    output logic [31:0]      address,
    output logic             pc_halt,
    output logic             in_isr,
    output logic [IDW-1:0]   isr_id,
    output logic             irq_ack
);

    logic [31:0]      address_q, address_d;
    logic [31:0]      resume_q, resume_d;
    logic [31:0]      jreg_q, jreg_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] clr;
    logic             jflag_q, jflag_d;
    logic             in_isr_q, in_isr_d;
    logic             irq_ack_q, irq_ack_d;
    logic [IDW-1:0]   isr_id_q, isr_id_d;
    logic [IDW-1:0]   entry_id;
    logic             halt;
    logic             entry;
    logic             exit_isr;
    logic             autoret;

    assign halt = (address_q == 32'd0);

    // Lowest-index pending source wins.
    always_comb begin
        entry_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i]) entry_id = IDW'(i);
        end
    end

    // No entry between a taken branch and its delay slot.
    assign entry = exec2 & ~halt & (|pend_q) & ~in_isr_q & ~jflag_q & ~jump_req;

    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_clr
            assign clr[gi] = entry && (entry_id == IDW'(gi));
        end
    endgenerate

`ifdef PC_ISR_AUTORET_EN
    localparam int CNT_W = $clog2(ISR_LEN + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign autoret = (cnt_q == CNT_W'(ISR_LEN));

    always_comb begin
        cnt_d = cnt_q;
        if (entry) begin
            cnt_d = CNT_W'(1);
        end else if (exec2 && in_isr_q && !exit_isr) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign autoret = 1'b0;
`endif

    assign exit_isr = exec2 & ~halt & ~entry & in_isr_q & (isr_return | autoret);

    always_comb begin
        address_d = address_q;
        resume_d  = resume_q;
        jflag_d   = jflag_q;
        jreg_d    = jreg_q;
        in_isr_d  = in_isr_q;
        isr_id_d  = isr_id_q;
        irq_ack_d = entry;
        pend_d    = (pend_q & ~clr) | irq;
        if (exec2) begin
            jflag_d = jump_req;
            jreg_d  = jump_req ? jump_target : 32'd0;
            if (halt) begin
                address_d = 32'd0;
            end else if (entry) begin
                address_d = ISR_BASE + ISR_STRIDE * {{(32-IDW){1'b0}}, entry_id};
                resume_d  = address_q + 32'd4;
                in_isr_d  = 1'b1;
                isr_id_d  = entry_id;
            end else if (exit_isr) begin
                // A branch issued on the returning instruction is dropped.
                address_d = resume_q;
                in_isr_d  = 1'b0;
                jflag_d   = 1'b0;
                jreg_d    = 32'd0;
            end else if (jflag_q) begin
                address_d = jreg_q;
            end else begin
                address_d = address_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            address_q <= RESET_VECTOR;
            resume_q  <= 32'd0;
            jreg_q    <= 32'd0;
            pend_q    <= '0;
            jflag_q   <= 1'b0;
            in_isr_q  <= 1'b0;
            irq_ack_q <= 1'b0;
            isr_id_q  <= '0;
        end else begin
            address_q <= address_d;
            resume_q  <= resume_d;
            jreg_q    <= jreg_d;
            pend_q    <= pend_d;
            jflag_q   <= jflag_d;
            in_isr_q  <= in_isr_d;
            irq_ack_q <= irq_ack_d;
            isr_id_q  <= isr_id_d;
        end
    end

    assign address = address_q;
    assign pc_halt = halt;
    assign in_isr  = in_isr_q;
    assign isr_id  = isr_id_q;
    assign irq_ack = irq_ack_q;

endmodule

// File: tb/tb_pc_irq_unit.sv
// Scoreboard bench for pc_irq_unit: directed scenarios then randomized traffic against a reference model.
module tb_pc_irq_unit;

    localparam int          N    = 4;
    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam logic [31:0] IB   = 32'hBFCF0000;
    localparam logic [31:0] IS   = 32'h100;
    localparam int          ILEN = 10;
`ifdef PC_ISR_AUTORET_EN
    localparam bit AUTORET = 1'b1;
`else
    localparam bit AUTORET = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          exec2 = 1'b0;
    logic          jump_req = 1'b0;
    logic [31:0]   jump_target = 32'd0;
    logic [N-1:0]  irq = '0;
    logic          isr_return = 1'b0;
    logic [31:0]   address;
    logic          pc_halt;
    logic          in_isr;
    logic [1:0]    isr_id;
    logic          irq_ack;

    pc_irq_unit #(
        .RESET_VECTOR(RV),
        .ISR_BASE    (IB),
        .ISR_STRIDE  (IS),
        .N_IRQ       (N),
        .ISR_LEN     (ILEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .exec2      (exec2),
        .jump_req   (jump_req),
        .jump_target(jump_target),
        .irq        (irq),
        .isr_return (isr_return),
        .address    (address),
        .pc_halt    (pc_halt),
        .in_isr     (in_isr),
        .isr_id     (isr_id),
        .irq_ack    (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          isr;
        int          id;
        bit          ack;
        bit          halt;
        bit          ex;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: architectural state described directly from the behavioural rules.
    bit [31:0] m_pc, m_resume, m_tgt;
    bit        m_branch_pending, m_isr;
    int        m_id, m_cnt;
    bit        m_req[N];

    task automatic model_reset();
        m_pc = RV; m_resume = 0; m_tgt = 0;
        m_branch_pending = 0; m_isr = 0; m_id = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) m_req[i] = 0;
    endtask

    task automatic step(input bit rst, input bit ex, input bit jr, input bit [31:0] jt,
                        input bit [N-1:0] rq, input bit ret);
        exp_t e;
        bit   enter;
        int   src;
        enter = 0;
        src   = -1;
        reset = rst; exec2 = ex; jump_req = jr; jump_target = jt; irq = rq; isr_return = ret;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = N - 1; i >= 0; i--) if (m_req[i]) src = i;
            if (ex) begin
                if (m_pc == 0) begin
                    m_branch_pending = jr; m_tgt = jt;
                end else if (src >= 0 && !m_isr && !m_branch_pending && !jr) begin
                    enter = 1;
                    m_resume = m_pc + 4;
                    m_pc = IB + 32'(src) * IS;
                    m_isr = 1; m_id = src; m_cnt = 1;
                    m_req[src] = 0;
                    m_branch_pending = 0;
                end else if (m_isr && (ret || (AUTORET && m_cnt == ILEN))) begin
                    m_pc = m_resume; m_isr = 0; m_branch_pending = 0;
                end else begin
                    if (m_branch_pending) m_pc = m_tgt;
                    else                  m_pc = m_pc + 4;
                    m_branch_pending = jr; m_tgt = jt;
                    if (m_isr) m_cnt++;
                end
            end
            for (int i = 0; i < N; i++) if (rq[i]) m_req[i] = 1;
        end
        e.addr = m_pc; e.isr = m_isr; e.id = m_id; e.ack = enter; e.halt = (m_pc == 0); e.ex = ex;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic rst();
        step(1, 0, 0, 0, '0, 0);
    endtask

    // One multicycle instruction: an idle cycle followed by the exec2 strobe.
    task automatic instr(input bit jr, input bit [31:0] jt, input bit ret);
        step(0, 0, 0, 0, '0, 0);
        step(0, 1, jr, jt, '0, ret);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s txn=%0d got=%h expected=%h", name, txn, got, want);
        end
    endtask

    // Monitor: one expected entry per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("address", address, e.addr);
                chk("in_isr", {31'd0, in_isr}, {31'd0, e.isr});
                chk("isr_id", {30'd0, isr_id}, 32'(e.id));
                chk("irq_ack", {31'd0, irq_ack}, {31'd0, e.ack});
                chk("pc_halt", {31'd0, pc_halt}, {31'd0, e.halt});
                if (e.ex) begin
                    txn++;
                    $display("txn %0d addr=%h in_isr=%0b isr_id=%0d irq_ack=%0b halt=%0b",
                             txn, address, in_isr, isr_id, irq_ack, pc_halt);
                end
            end
        end
    end

    initial begin
        bit          r_rst, r_ex, r_jr, r_ret;
        bit [31:0]   r_jt;
        bit [N-1:0]  r_rq;

        // Reset and straight-line stepping.
        rst(); rst();
        repeat (3) instr(0, 0, 0);

        // Taken branch with one delay slot.
        rst();
        instr(0, 0, 0);
        instr(1, 32'hBFC00100, 0);
        instr(0, 0, 0);
        instr(0, 0, 0);

        // Two sources pending at once: lowest first, the other after return.
        rst();
        repeat (4) instr(0, 0, 0);
        step(0, 0, 0, 0, 4'b0110, 0);
        step(0, 1, 0, 0, '0, 0);
        instr(0, 0, 0);
        instr(0, 0, 1);
        instr(0, 0, 0);
        instr(0, 0, 0);
        instr(0, 0, 1);
        instr(0, 0, 0);

        // irq with a taken branch: delay slot and target run before entry.
        rst();
        instr(0, 0, 0);
        step(0, 1, 1, 32'hBFC00200, 4'b0001, 0);
        instr(0, 0, 0);
        instr(0, 0, 0);
        instr(0, 0, 1);
        instr(0, 0, 0);

        // Long ISR: automatic return only when the option is built in.
        rst();
        step(0, 0, 0, 0, 4'b0001, 0);
        step(0, 1, 0, 0, '0, 0);
        repeat (12) instr(0, 0, 0);
        instr(0, 0, 1);
        instr(0, 0, 0);

        // Branch to zero halts; halt survives exec2 and irq until reset.
        rst();
        instr(1, 32'd0, 0);
        instr(0, 0, 0);
        step(0, 1, 0, 0, 4'b1111, 0);
        instr(1, 32'hBFC00040, 0);
        instr(0, 0, 0);
        rst();
        instr(0, 0, 0);

        // Wrap from FFFFFFFC to zero.
        rst();
        instr(1, 32'hFFFFFFF8, 0);
        repeat (4) instr(0, 0, 0);

        // Reset in the middle of an ISR drops it and everything pending.
        rst();
        step(0, 0, 0, 0, 4'b0010, 0);
        step(0, 1, 0, 0, 4'b1000, 0);
        step(1, 0, 0, 0, 4'b0100, 0);
        repeat (2) instr(0, 0, 0);

        // Randomized traffic.
        for (int seg = 0; seg < 8; seg++) begin
            rst();
            for (int c = 0; c < 150; c++) begin
                r_rst = ($urandom % 200) == 0;
                r_ex  = ($urandom % 2) == 0;
                r_jr  = ($urandom % 8) == 0;
                r_jt  = RV + ($urandom_range(0, 511) << 2);
                r_rq  = (($urandom % 6) == 0) ? N'($urandom) : '0;
                r_ret = ($urandom % 5) == 0;
                step(r_rst, r_ex, r_jr, r_jt, r_rq, r_ret);
            end
        end

        exec2 = 0; jump_req = 0; irq = '0; isr_return = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_irq_unit.md
# pc_irq_unit

Parametrised program counter with vectored, multi-source interrupt handling for the multicycle MIPS core. It advances the PC once per instruction on the `exec2` strobe, applies taken branches/jumps after one delay slot, and enters one of `N_IRQ` interrupt service routines at a per-source vector. On ISR exit it resumes the interrupted program. Target computation moves to the decoder; this block owns sequencing, delay-slot tracking and ISR entry/exit.

## Interface
- `RESET_VECTOR`, default 32'hBFC00000, PC value after reset.
- `ISR_BASE`, default 32'hBFCF0000, vector of IRQ source 0.
- `ISR_STRIDE`, default 32'h100, byte spacing between per-source vectors.
- `N_IRQ`, default 4, number of interrupt sources; legal range 1..16.
- `ISR_LEN`, default 10, instruction count before automatic return; legal range 1..255; used only with `PC_ISR_AUTORET_EN`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `exec2` in 1: end-of-instruction strobe; all PC updates happen on this strobe.
- `jump_req` in 1: the current instruction's branch/jump is taken. Sampled on `exec2`.
- `jump_target` in 32: destination for `jump_req`.
- `irq` in N_IRQ: interrupt request per source, sampled every cycle.
- `isr_return` in 1: explicit ISR exit. Sampled on `exec2`.
- `address` out 32: current PC.
- `pc_halt` out 1: combinational, `address == 0`.
- `in_isr` out 1: an ISR is executing.
- `isr_id` out $clog2(N_IRQ) (min 1): source being serviced; holds its last value after exit.
- `irq_ack` out 1: one-cycle pulse when an ISR is entered.

## Operation
- Pending register `pend[N_IRQ]`: `pend <= (pend & ~clr) | irq` every cycle. `clr` is the one-hot bit of the source being entered. A source whose `irq` is still high at entry re-pends immediately.
- Delay-slot latch: on every `exec2`, set `jflag <= jump_req` and `jreg <= jump_target` (`jreg <= 0` if no request). The latch is also captured inside ISRs.
- PC update on `exec2`, first matching rule wins:
  1. `pc_halt`: `address <= 0`. Halt is sticky until reset.
  2. Entry: taken when `|pend & !in_isr & !jflag & !jump_req`. This blocks entry between a jump and its delay slot.
     - `id` is the lowest-index pending source.
     - `address <= ISR_BASE + id*ISR_STRIDE`, `resume <= address+4`.
     - Set `in_isr`, `isr_id <= id`, `irq_ack <= 1`, `cnt <= 1`.
  3. Exit: taken when `in_isr` and (`isr_return`, or `cnt == ISR_LEN` with the macro enabled).
     - `address <= resume`, clear `in_isr`, `jflag <= 0`.
     - A `jump_req` on the exit strobe is discarded.
  4. Otherwise, if `jflag`: `address <= jreg`.
  5. Otherwise: `address <= address + 4`.
- Inside an ISR, each `exec2` that does not exit increments `cnt`. `cnt` is $clog2(ISR_LEN+1) bits. No nesting: requests arriving during an ISR stay pending and are taken on a later `exec2` after exit.
- All arithmetic is mod 2^32; `address + 4` wraps from 32'hFFFFFFFC to 0, which then halts.

## Timing
- Reset values:
  - `address = RESET_VECTOR`, `pend = 0`, `jflag = 0`, `jreg = 0`.
  - `in_isr = 0`, `isr_id = 0`, `irq_ack = 0`, `cnt = 0`, `resume = 0`.
- Reset mid-ISR aborts the ISR and drops all pending requests.
- Branch latency: `jump_req` on instruction at A means A+4 executes, then `jump_target`. The delay slot is one instruction.
- IRQ latency: `irq` high for at least one cycle before an eligible `exec2` causes entry on that `exec2`. `irq` asserted in the same cycle as `exec2` is serviced on the next `exec2`.
- `irq_ack` is high for exactly the cycle after the entry edge. `isr_id` is valid from that same cycle.
- `address` changes only on `posedge clk` with `exec2 = 1`, or on reset.

## Configuration
- `PC_ISR_AUTORET_EN` defined: the ISR also exits automatically on the `exec2` where `cnt == ISR_LEN`, i.e. after `ISR_LEN` ISR instructions. `isr_return` exits earlier.
- Not defined: `cnt` logic is removed and the ISR exits only on `isr_return`.

## Test plan
- Reset then 3 `exec2` pulses -> `address` steps BFC00000, BFC00004, BFC00008, BFC0000C. `in_isr = 0`, `irq_ack = 0`.
- Jump at BFC00004 with `jump_target = BFC00100` -> next PCs BFC00008, then BFC00100.
- Pulse `irq = 4'b0110` at PC BFC00010 -> `address = BFCF0100`, `isr_id = 1`, `irq_ack` pulses once. After `isr_return`, `address = BFC00014`. The next `exec2` enters the vector for `isr_id = 2`, BFCF0200.
- `irq` raised in the same `exec2` as `jump_req` -> delay slot, then jump target, executes first. Entry occurs on the following `exec2`, with `resume = target + 4`.
- With `PC_ISR_AUTORET_EN` and `ISR_LEN = 10` -> ISR PCs BFCF0000..BFCF0024, then the PC returns to `resume`. Without the macro -> the PC continues to BFCF0028.
- `jump_target = 0` taken -> `pc_halt = 1` and `address` stays 0 under further `exec2` and `irq`. Reset -> BFC00000.
